// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE,
    WAIT_RELEASE
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the lab top level and the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             Run;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Run, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );

  modport slave (
    input  Run, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
endinterface

// File: rtl/borrow_subtractor.sv
// (WIDTH+1)-bit ripple subtractor a - b built as a + ~b + 1 from full adders.
module borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           borrow_o
);
  logic [WIDTH+1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (~b_i[i]),
      .cin_i (carry[i]),
      .s_o   (diff_o[i]),
      .cout_o(carry[i+1])
    );
  end

  // No carry out of a + ~b + 1 means b > a.
  assign borrow_o = ~carry[WIDTH+1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the adder, multiplier and divider datapaths.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider producing one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  seq_divider_if.slave bus
);
  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;
  logic [WIDTH-1:0] r_reg_q, r_reg_d;
  logic [WIDTH-1:0] d_reg_q, d_reg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_msb_unused;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // The partial remainder is always below the divisor before a shift, so its
  // top bit is zero and the shifted value fits the WIDTH+1-bit subtractor.
  assign r_shift = {r_reg_q, q_reg_q[WIDTH-1]};

  borrow_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a_i     (r_shift),
    .b_i     ({1'b0, d_reg_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign diff_msb_unused = diff[WIDTH];
  assign q_next = {q_reg_q[WIDTH-2:0], ~borrow};
  assign r_next = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_reg_d = q_reg_q;
    r_reg_d = r_reg_q;
    d_reg_d = d_reg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Run) begin
          if (bus.Divisor != '0) begin
            state_d = COMPUTE;
            q_reg_d = bus.Dividend;
            r_reg_d = '0;
            d_reg_d = bus.Divisor;
            count_d = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.Dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      COMPUTE: begin
        q_reg_d = q_next;
        r_reg_d = r_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          quot_d  = q_next;
          rem_d   = r_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = bus.Run ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (!bus.Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are always reloaded on accept, so they need no reset.
  always_ff @(posedge Clk) begin
    q_reg_q <= q_reg_d;
    r_reg_q <= r_reg_d;
    d_reg_q <= d_reg_d;
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Busy      = (state_q == COMPUTE);
  assign bus.Done      = (state_q == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized operands vs. an arithmetic model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int   lat, busy_cnt;
  bit   done_seen, q_stable;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it until Done, bounded to 40 cycles.
  task automatic op(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit hold, input bit scramble);
    logic [W-1:0] q_before;
    q_before = bus.Quotient;
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.Dividend = dd;
    bus.Divisor = dv;
    @(posedge Clk); #1;
    if (!hold) bus.Run = 1'b0;
    if (scramble) begin
      bus.Dividend = '0;
      bus.Divisor = '0;
    end
    busy_cnt = 0;
    lat = 0;
    done_seen = 0;
    q_stable = 1;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (bus.Done) done_seen = 1;
      else begin
        if (bus.Busy) busy_cnt++;
        if (bus.Quotient !== q_before) q_stable = 0;
        @(posedge Clk); #1;
        lat++;
      end
    end
  endtask

  task automatic op_check(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input bit hold, input bit scramble);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           elat;
    if (dv == 0) begin
      eq = '1; er = dd; edbz = 1'b1; elat = 0;
    end else begin
      eq = W'(int'(dd) / int'(dv)); er = W'(int'(dd) % int'(dv)); edbz = 1'b0; elat = W;
    end
    op(dd, dv, hold, scramble);
    check({name, " done_seen"}, 32'(done_seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(elat));
    check({name, " result_stable_while_busy"}, 32'(q_stable), 32'd1);
    check({name, " quotient"}, 32'(bus.Quotient), 32'(eq));
    check({name, " remainder"}, 32'(bus.Remainder), 32'(er));
    check({name, " divbyzero"}, 32'(bus.DivByZero), 32'(edbz));
    if (dv != 0)
      check({name, " identity"}, 32'(int'(bus.Quotient) * int'(dv) + int'(bus.Remainder)), 32'(dd));
    @(posedge Clk); #1;
    check({name, " done_one_cycle"}, 32'(bus.Done), 32'd0);
    check({name, " quotient_hold"}, 32'(bus.Quotient), 32'(eq));
  endtask

  initial begin
    int extra_done, busy_seen;
    logic [W-1:0] rdd, rdv;
    bit rhold;

    bus.Run = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset quotient", 32'(bus.Quotient), 32'd0);
    check("reset remainder", 32'(bus.Remainder), 32'd0);
    check("reset busy", 32'(bus.Busy), 32'd0);
    check("reset done", 32'(bus.Done), 32'd0);
    check("reset divbyzero", 32'(bus.DivByZero), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    op_check("100/7", 8'd100, 8'd7, 0, 0);
    op_check("255/1", 8'd255, 8'd1, 0, 0);
    op_check("200/200", 8'd200, 8'd200, 0, 0);
    op_check("254/255", 8'd254, 8'd255, 0, 0);
    op_check("5/0", 8'd5, 8'd0, 0, 0);
    op_check("9/3", 8'd9, 8'd3, 0, 0);

    // Held Run: a single Done, no retrigger until released.
    op_check("50/6 held", 8'd50, 8'd6, 1, 0);
    extra_done = 0;
    busy_seen = 0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (bus.Done) extra_done++;
      if (bus.Busy) busy_seen++;
    end
    check("held extra_done", 32'(extra_done), 32'd0);
    check("held busy", 32'(busy_seen), 32'd0);
    check("held quotient", 32'(bus.Quotient), 32'd8);
    check("held remainder", 32'(bus.Remainder), 32'd2);
    @(negedge Clk);
    bus.Run = 1'b0;
    @(posedge Clk); #1;

    op_check("60/4 scrambled", 8'd60, 8'd4, 0, 1);

    // Reset asserted before the fourth iteration of 77/5.
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.Dividend = 8'd77;
    bus.Divisor = 8'd5;
    @(posedge Clk); #1;
    bus.Run = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("abort quotient", 32'(bus.Quotient), 32'd0);
    check("abort remainder", 32'(bus.Remainder), 32'd0);
    check("abort busy", 32'(bus.Busy), 32'd0);
    check("abort done", 32'(bus.Done), 32'd0);
    check("abort divbyzero", 32'(bus.DivByZero), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    extra_done = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (bus.Done || bus.Busy) extra_done++;
    end
    check("abort no_done", 32'(extra_done), 32'd0);
    op_check("77/5 fresh", 8'd77, 8'd5, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rdd = W'($urandom_range(0, 255));
      rdv = (i % 6 == 5) ? '0 : W'($urandom_range(1, 255));
      rhold = (i % 5 == 3);
      op_check($sformatf("rand%0d %0d/%0d", i, rdd, rdv), rdd, rdv, rhold, i[0]);
      @(negedge Clk);
      bus.Run = 1'b0;
      @(posedge Clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
